// File: rtl/controle_gera_frame_if.sv
// rtl/controle_gera_frame_if.sv - handshake/bus bundle for the frame-generation control unit
//
// Groups every non-clock/reset signal of controle_gera_frame.
//   slave  : the control unit (consumes request, limits, loaded flag, clear-done; drives scan outputs)
//   master : the environment (frame requester, object memory, frame memory)
// Parameters must match those of the controle_gera_frame instance it is bound to.
interface controle_gera_frame_if #(
    parameter int NUM_CANAIS = 2,
    parameter int PROF_BITS  = 4
);
    localparam int CANAL_BITS = (NUM_CANAIS > 1) ? $clog2(NUM_CANAIS) : 1;
    localparam int CONT_BITS  = PROF_BITS + CANAL_BITS + 1;

    logic                           gera_frame;
    logic [NUM_CANAIS*PROF_BITS-1:0] limite;
    logic                           loaded;
    logic                           mem_pronta;
    logic [CANAL_BITS-1:0]          canal_sel;
    logic [PROF_BITS-1:0]           endereco_slot;
    logic                           clear_mem_frame;
    logic                           enable_mem_frame;
    logic [CONT_BITS-1:0]           contagem_objetos;
    logic                           ocupado;
    logic                           fim_gera_frame;
    logic [3:0]                     db_estado;

    modport master (
        output gera_frame, limite, loaded, mem_pronta,
        input  canal_sel, endereco_slot, clear_mem_frame, enable_mem_frame,
               contagem_objetos, ocupado, fim_gera_frame, db_estado
    );

    modport slave (
        input  gera_frame, limite, loaded, mem_pronta,
        output canal_sel, endereco_slot, clear_mem_frame, enable_mem_frame,
               contagem_objetos, ocupado, fim_gera_frame, db_estado
    );
endinterface

// File: rtl/controle_gera_frame.sv
// rtl/controle_gera_frame.sv - frame-generation control unit (clear, slot scan, write strobes)
//
// On gera_frame: clear frame memory, wait for mem_pronta, then scan slots 0..limit of
// channels 0..NUM_CANAIS-1, strobing enable_mem_frame once per loaded slot; ends with a
// one-cycle fim_gera_frame.
// Ports: clock, reset (sync, active-high), bus (controle_gera_frame_if.slave):
//   in : gera_frame, limite, loaded, mem_pronta
//   out: canal_sel, endereco_slot, clear_mem_frame, enable_mem_frame,
//        contagem_objetos, ocupado, fim_gera_frame, db_estado
// Optional: GERA_FRAME_REINICIO_EN - gera_frame in LIMPA..PROXIMO restarts the frame.
module controle_gera_frame #(
    parameter int NUM_CANAIS = 2,
    parameter int PROF_BITS  = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    controle_gera_frame_if.slave bus
);
    localparam int CANAL_BITS = (NUM_CANAIS > 1) ? $clog2(NUM_CANAIS) : 1;
    localparam int CONT_BITS  = PROF_BITS + CANAL_BITS + 1;

    typedef enum logic [3:0] {
        INICIAL         = 4'd0,
        ESPERA          = 4'd1,
        LIMPA           = 4'd2,
        AGUARDA_LIMPEZA = 4'd3,
        VERIFICA        = 4'd4,
        SALVA           = 4'd5,
        PROXIMO         = 4'd6,
        SINALIZA        = 4'd7
    } estado_t;

    estado_t               estado, prox_estado;
    logic [CANAL_BITS-1:0] canal_q;
    logic [PROF_BITS-1:0]  slot_q;
    logic [CONT_BITS-1:0]  cont_q;
    logic [PROF_BITS-1:0]  lim_q [NUM_CANAIS];
    logic [PROF_BITS-1:0]  lim_atual;
    logic                  slot_ultimo;
    logic                  canal_ultimo;

    // Limit of the channel being scanned, taken from the copy latched in LIMPA so that
    // later changes of limite cannot affect the frame in progress.
    always_comb begin
        lim_atual = '0;
        for (int k = 0; k < NUM_CANAIS; k++) begin
            if (canal_q == CANAL_BITS'(k)) begin
                lim_atual = lim_q[k];
            end
        end
    end

    assign slot_ultimo  = (slot_q >= lim_atual);
    assign canal_ultimo = (canal_q >= CANAL_BITS'(NUM_CANAIS - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            estado  <= INICIAL;
            canal_q <= '0;
            slot_q  <= '0;
            cont_q  <= '0;
            for (int k = 0; k < NUM_CANAIS; k++) begin
                lim_q[k] <= '0;
            end
        end else begin
            estado <= prox_estado;
            case (estado)
                LIMPA: begin
                    canal_q <= '0;
                    slot_q  <= '0;
                    cont_q  <= '0;
                    for (int k = 0; k < NUM_CANAIS; k++) begin
                        lim_q[k] <= bus.limite[k*PROF_BITS +: PROF_BITS];
                    end
                end
                SALVA: cont_q <= cont_q + CONT_BITS'(1);
                PROXIMO: begin
                    if (!slot_ultimo) begin
                        slot_q <= slot_q + PROF_BITS'(1);
                    end else if (!canal_ultimo) begin
                        canal_q <= canal_q + CANAL_BITS'(1);
                        slot_q  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        prox_estado = estado;
        case (estado)
            INICIAL:         prox_estado = ESPERA;
            ESPERA:          if (bus.gera_frame) prox_estado = LIMPA;
            LIMPA:           prox_estado = AGUARDA_LIMPEZA;
            AGUARDA_LIMPEZA: if (bus.mem_pronta) prox_estado = VERIFICA;
            VERIFICA:        prox_estado = bus.loaded ? SALVA : PROXIMO;
            SALVA:           prox_estado = PROXIMO;
            PROXIMO:         prox_estado = (slot_ultimo && canal_ultimo) ? SINALIZA : VERIFICA;
            SINALIZA:        prox_estado = ESPERA;
            default:         prox_estado = INICIAL;
        endcase
`ifdef GERA_FRAME_REINICIO_EN
        // A new request mid-frame abandons the current frame; SINALIZA is excluded so a
        // finished frame always reports completion.
        if (bus.gera_frame && (estado inside {LIMPA, AGUARDA_LIMPEZA, VERIFICA, SALVA, PROXIMO})) begin
            prox_estado = LIMPA;
        end
`else
`endif
    end

    assign bus.canal_sel        = canal_q;
    assign bus.endereco_slot    = slot_q;
    assign bus.contagem_objetos = cont_q;
    assign bus.clear_mem_frame  = (estado == LIMPA);
    assign bus.enable_mem_frame = (estado == SALVA);
    assign bus.fim_gera_frame   = (estado == SINALIZA);
    assign bus.ocupado          = (estado != INICIAL) && (estado != ESPERA);
    assign bus.db_estado        = (estado > SINALIZA) ? 4'hF : 4'(estado);
endmodule

// File: tb/tb_controle_gera_frame.sv
// tb/tb_controle_gera_frame.sv - self-checking bench for controle_gera_frame
module tb_controle_gera_frame;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    controle_gera_frame_if #(.NUM_CANAIS(2), .PROF_BITS(4)) bus ();
    controle_gera_frame #(.NUM_CANAIS(2), .PROF_BITS(4)) dut (
        .clock(clock), .reset(reset), .bus(bus.slave));

    controle_gera_frame_if #(.NUM_CANAIS(3), .PROF_BITS(2)) bus2 ();
    controle_gera_frame #(.NUM_CANAIS(3), .PROF_BITS(2)) dut2 (
        .clock(clock), .reset(reset), .bus(bus2.slave));

    int n_assert = 0;
    int n_fail   = 0;

    // Object memory model: per-channel loaded bitmaps.
    logic [15:0] mask [2];
    assign bus.loaded  = mask[bus.canal_sel][bus.endereco_slot];
    assign bus2.loaded = 1'b1;

    logic [4:0] exp_q [$];
    int exp_s, exp_l;
    bit sb_en = 1'b0;
    int n_wr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: each write strobe must match the next expected (channel, slot).
    always @(negedge clock) begin
        if (sb_en && bus.enable_mem_frame) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                n_assert++;
                assert (0) else begin
                    n_fail++;
                    $error("FAIL sb_unexpected_write observed=%0d expected=none",
                           {bus.canal_sel, bus.endereco_slot});
                end
            end else begin
                logic [4:0] e;
                e = exp_q.pop_front();
                n_assert++;
                assert ({bus.canal_sel, bus.endereco_slot} === e) else begin
                    n_fail++;
                    $error("FAIL sb_write_addr observed=%0d expected=%0d",
                           {bus.canal_sel, bus.endereco_slot}, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic prep(input logic [3:0] l0, input logic [3:0] l1,
                        input logic [15:0] m0, input logic [15:0] m1);
        logic [3:0]  lim [2];
        logic [15:0] mm  [2];
        lim[0] = l0; lim[1] = l1; mm[0] = m0; mm[1] = m1;
        bus.limite = {l1, l0};
        mask[0] = m0;
        mask[1] = m1;
        exp_q.delete();
        exp_s = 0;
        exp_l = 0;
        for (int c = 0; c < 2; c++) begin
            for (int s = 0; s <= int'(lim[c]); s++) begin
                exp_s++;
                if (mm[c][s]) begin
                    exp_l++;
                    exp_q.push_back({c[0], s[3:0]});
                end
            end
        end
    endtask

    // r: cycle during which mem_pronta rises (2 = already high). Cycle 1 is LIMPA.
    task automatic run_frame(input string tag, input int r, input bit pulse_prox);
        int fim_cyc, nclr, bad_wait, exp_fim;
        bit pulsed;
        exp_fim = 3 + 2 * exp_s + exp_l + (r - 2);
        bus.mem_pronta = (r <= 2);
        n_wr = 0; sb_en = 1'b1; nclr = 0; bad_wait = 0; fim_cyc = -1; pulsed = 1'b0;
        bus.gera_frame = 1'b1;
        step();
        for (int cyc = 1; cyc <= 300; cyc++) begin
            if (cyc > 1) step();
            bus.gera_frame = 1'b0;
            if (cyc == 1) chk({tag, "_clear_c1"}, bus.clear_mem_frame, 1);
            nclr += int'(bus.clear_mem_frame);
            if (cyc >= 2 && cyc <= r && bus.db_estado != 4'd3) bad_wait++;
            if (cyc == r) bus.mem_pronta = 1'b1;
            if (pulse_prox && !pulsed && bus.db_estado == 4'd6) begin
                bus.gera_frame = 1'b1;
                pulsed = 1'b1;
            end
            if (bus.fim_gera_frame) begin
                fim_cyc = cyc;
                break;
            end
        end
        chk({tag, "_fim_cycle"}, fim_cyc, exp_fim);
        chk({tag, "_writes"}, n_wr, exp_l);
        chk({tag, "_sb_left"}, exp_q.size(), 0);
        chk({tag, "_clear_count"}, nclr, 1);
        chk({tag, "_wait_state"}, bad_wait, 0);
        step();
        chk({tag, "_back_espera"}, bus.db_estado, 1);
        chk({tag, "_fim_one_cycle"}, bus.fim_gera_frame, 0);
        chk({tag, "_ocupado_idle"}, bus.ocupado, 0);
        chk({tag, "_count_hold"}, bus.contagem_objetos, exp_l);
        sb_en = 1'b0;
    endtask

    initial begin
        int nfim, fc;
        bit seen;
        bus.gera_frame = 1'b0; bus.limite = '0; bus.mem_pronta = 1'b1;
        mask[0] = '0; mask[1] = '0;
        bus2.gera_frame = 1'b0; bus2.limite = '0; bus2.mem_pronta = 1'b1;
        reset = 1'b1;
        repeat (2) step();
        chk("reset_db", bus.db_estado, 0);
        chk("reset_outs", {bus.canal_sel, bus.endereco_slot, bus.clear_mem_frame,
                           bus.enable_mem_frame, bus.contagem_objetos, bus.ocupado,
                           bus.fim_gera_frame}, 0);
        reset = 1'b0;
        step();
        chk("idle_espera", bus.db_estado, 1);

        // No loaded slots, limits {3,1}: fim in cycle 15.
        prep(4'd3, 4'd1, 16'h0000, 16'h0000);
        run_frame("empty", 2, 1'b0);

        // Mixed: limits {1,0}, loaded (0,1),(1,0): fim in cycle 11.
        prep(4'd1, 4'd0, 16'h0002, 16'h0001);
        run_frame("mixed", 2, 1'b0);

        // Clear wait of 10 extra cycles.
        prep(4'd1, 4'd0, 16'h0001, 16'h0000);
        run_frame("clrwait", 12, 1'b0);

        // Reset in SALVA aborts the frame.
        prep(4'd3, 4'd1, 16'hFFFF, 16'hFFFF);
        sb_en = 1'b0;
        bus.gera_frame = 1'b1;
        step();
        bus.gera_frame = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (bus.db_estado == 4'd5) seen = 1'b1;
            else step();
        end
        chk("rst_reach_salva", seen, 1);
        reset = 1'b1;
        step();
        chk("rst_mid_db", bus.db_estado, 0);
        chk("rst_mid_outs", {bus.canal_sel, bus.endereco_slot, bus.clear_mem_frame,
                             bus.enable_mem_frame, bus.contagem_objetos, bus.ocupado,
                             bus.fim_gera_frame}, 0);
        reset = 1'b0;
        nfim = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            nfim += int'(bus.fim_gera_frame);
        end
        chk("rst_no_fim", nfim, 0);
        chk("rst_idle", bus.db_estado, 1);
        exp_q.delete();

        // Request during PROXIMO.
        prep(4'd1, 4'd0, 16'h0001, 16'h0000);
`ifdef GERA_FRAME_REINICIO_EN
        sb_en = 1'b0;
        bus.gera_frame = 1'b1;
        step();
        bus.gera_frame = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (bus.db_estado == 4'd6) seen = 1'b1;
            else step();
        end
        chk("restart_reach_prox", seen, 1);
        chk("restart_count_before", bus.contagem_objetos, 1);
        bus.gera_frame = 1'b1;
        step();
        bus.gera_frame = 1'b0;
        chk("restart_limpa", bus.db_estado, 2);
        step();
        chk("restart_count_clr", bus.contagem_objetos, 0);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (bus.fim_gera_frame) seen = 1'b1;
            else step();
        end
        chk("restart_fim", seen, 1);
        chk("restart_count_final", bus.contagem_objetos, 1);
        exp_q.delete();
        step();
`else
        run_frame("noreinicio", 2, 1'b1);
`endif

        // Full depth on the 3x4 instance: 12 slots, all loaded, fim in cycle 39.
        bus2.limite = {2'd3, 2'd3, 2'd3};
        bus2.gera_frame = 1'b1;
        step();
        bus2.gera_frame = 1'b0;
        fc = -1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (cyc > 1) step();
            if (bus2.fim_gera_frame) begin
                fc = cyc;
                break;
            end
        end
        chk("full_fim_cycle", fc, 39);
        chk("full_count", bus2.contagem_objetos, 12);
        chk("full_canal", bus2.canal_sel, 2);
        chk("full_slot", bus2.endereco_slot, 3);
        step();
        chk("full_hold_count", bus2.contagem_objetos, 12);
        chk("full_hold_canal", bus2.canal_sel, 2);
        chk("full_espera", bus2.db_estado, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
